// File: rtl/alu_unit.sv
// Single-cycle RV32I integer execution unit feeding the ALU common data bus.
// Accepts one issue per cycle from the reservation station and registers the broadcast.
module alu_unit (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_rdy,
    input  logic        in_clear,
    input  logic        in_rs_enable,
    input  logic [5:0]  in_rs_type,
    input  logic [31:0] in_rs_pc,
    input  logic [31:0] in_rs_imm,
    input  logic [31:0] in_rs_left_oprand,
    input  logic [31:0] in_rs_right_oprand,
    input  logic [3:0]  in_rs_dest,
    output logic        out_broadcast_enable,
    output logic [3:0]  out_broadcast_reorder,
    output logic [31:0] out_broadcast_result,
    output logic        out_broadcast_jump,
    output logic [31:0] out_broadcast_target
);

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned ADDRESS_WIDTH  = 32;
    localparam int unsigned ROB_WIDTH      = 4;
    localparam int unsigned OPERATOR_WIDTH = 6;

    localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;

    // Operator codes; 11..18 are the load/store codes, which this unit treats as unknown.
    localparam logic [OPERATOR_WIDTH-1:0] OP_LUI   = 6'd1;
    localparam logic [OPERATOR_WIDTH-1:0] OP_AUIPC = 6'd2;
    localparam logic [OPERATOR_WIDTH-1:0] OP_JAL   = 6'd3;
    localparam logic [OPERATOR_WIDTH-1:0] OP_JALR  = 6'd4;
    localparam logic [OPERATOR_WIDTH-1:0] OP_BEQ   = 6'd5;
    localparam logic [OPERATOR_WIDTH-1:0] OP_BNE   = 6'd6;
    localparam logic [OPERATOR_WIDTH-1:0] OP_BLT   = 6'd7;
    localparam logic [OPERATOR_WIDTH-1:0] OP_BGE   = 6'd8;
    localparam logic [OPERATOR_WIDTH-1:0] OP_BLTU  = 6'd9;
    localparam logic [OPERATOR_WIDTH-1:0] OP_BGEU  = 6'd10;
    localparam logic [OPERATOR_WIDTH-1:0] OP_ADDI  = 6'd19;
    localparam logic [OPERATOR_WIDTH-1:0] OP_SLTI  = 6'd20;
    localparam logic [OPERATOR_WIDTH-1:0] OP_SLTIU = 6'd21;
    localparam logic [OPERATOR_WIDTH-1:0] OP_XORI  = 6'd22;
    localparam logic [OPERATOR_WIDTH-1:0] OP_ORI   = 6'd23;
    localparam logic [OPERATOR_WIDTH-1:0] OP_ANDI  = 6'd24;
    localparam logic [OPERATOR_WIDTH-1:0] OP_SLLI  = 6'd25;
    localparam logic [OPERATOR_WIDTH-1:0] OP_SRLI  = 6'd26;
    localparam logic [OPERATOR_WIDTH-1:0] OP_SRAI  = 6'd27;
    localparam logic [OPERATOR_WIDTH-1:0] OP_ADD   = 6'd28;
    localparam logic [OPERATOR_WIDTH-1:0] OP_SUB   = 6'd29;
    localparam logic [OPERATOR_WIDTH-1:0] OP_SLL   = 6'd30;
    localparam logic [OPERATOR_WIDTH-1:0] OP_SLT   = 6'd31;
    localparam logic [OPERATOR_WIDTH-1:0] OP_SLTU  = 6'd32;
    localparam logic [OPERATOR_WIDTH-1:0] OP_XOR   = 6'd33;
    localparam logic [OPERATOR_WIDTH-1:0] OP_SRL   = 6'd34;
    localparam logic [OPERATOR_WIDTH-1:0] OP_SRA   = 6'd35;
    localparam logic [OPERATOR_WIDTH-1:0] OP_OR    = 6'd36;
    localparam logic [OPERATOR_WIDTH-1:0] OP_AND   = 6'd37;

    typedef enum logic [3:0] {
        FnAdd, FnSub, FnSll, FnSlt, FnSltu, FnXor, FnSrl, FnSra, FnOr, FnAnd
    } alu_fn_e;

    typedef enum logic [1:0] {
        ClsNone, ClsAlu, ClsBranch, ClsOther
    } op_class_e;

    // Operator decode: class, ALU function and second-operand source.
    alu_fn_e   alu_fn;
    op_class_e op_class;
    logic      use_imm;

    always_comb begin
        alu_fn   = FnAdd;
        op_class = ClsNone;
        use_imm  = 1'b0;
        case (in_rs_type)
            OP_ADD:   begin op_class = ClsAlu; alu_fn = FnAdd;  end
            OP_SUB:   begin op_class = ClsAlu; alu_fn = FnSub;  end
            OP_SLL:   begin op_class = ClsAlu; alu_fn = FnSll;  end
            OP_SLT:   begin op_class = ClsAlu; alu_fn = FnSlt;  end
            OP_SLTU:  begin op_class = ClsAlu; alu_fn = FnSltu; end
            OP_XOR:   begin op_class = ClsAlu; alu_fn = FnXor;  end
            OP_SRL:   begin op_class = ClsAlu; alu_fn = FnSrl;  end
            OP_SRA:   begin op_class = ClsAlu; alu_fn = FnSra;  end
            OP_OR:    begin op_class = ClsAlu; alu_fn = FnOr;   end
            OP_AND:   begin op_class = ClsAlu; alu_fn = FnAnd;  end
            OP_ADDI:  begin op_class = ClsAlu; alu_fn = FnAdd;  use_imm = 1'b1; end
            OP_SLTI:  begin op_class = ClsAlu; alu_fn = FnSlt;  use_imm = 1'b1; end
            OP_SLTIU: begin op_class = ClsAlu; alu_fn = FnSltu; use_imm = 1'b1; end
            OP_XORI:  begin op_class = ClsAlu; alu_fn = FnXor;  use_imm = 1'b1; end
            OP_ORI:   begin op_class = ClsAlu; alu_fn = FnOr;   use_imm = 1'b1; end
            OP_ANDI:  begin op_class = ClsAlu; alu_fn = FnAnd;  use_imm = 1'b1; end
            OP_SLLI:  begin op_class = ClsAlu; alu_fn = FnSll;  use_imm = 1'b1; end
            OP_SRLI:  begin op_class = ClsAlu; alu_fn = FnSrl;  use_imm = 1'b1; end
            OP_SRAI:  begin op_class = ClsAlu; alu_fn = FnSra;  use_imm = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: op_class = ClsBranch;
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:                op_class = ClsOther;
            default:  op_class = ClsNone;
        endcase
    end

    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [4:0]            shamt;
    logic                  lt_signed;
    logic                  lt_unsigned;
    logic [DATA_WIDTH-1:0] alu_out;

    assign op_a        = in_rs_left_oprand;
    assign op_b        = use_imm ? in_rs_imm : in_rs_right_oprand;
    assign shamt       = op_b[4:0];
    assign lt_signed   = $signed(op_a) < $signed(op_b);
    assign lt_unsigned = op_a < op_b;

    always_comb begin
        alu_out = '0;
        case (alu_fn)
            FnAdd:   alu_out = op_a + op_b;
            FnSub:   alu_out = op_a - op_b;
            FnSll:   alu_out = op_a << shamt;
            FnSlt:   alu_out = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
            FnSltu:  alu_out = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
            FnXor:   alu_out = op_a ^ op_b;
            FnSrl:   alu_out = op_a >> shamt;
            FnSra:   alu_out = $unsigned($signed(op_a) >>> shamt);
            FnOr:    alu_out = op_a | op_b;
            FnAnd:   alu_out = op_a & op_b;
            default: alu_out = '0;
        endcase
    end

    // Branch conditions always compare rs1 against rs2, never the immediate.
    logic br_eq;
    logic br_lt;
    logic br_ltu;
    logic br_taken;

    assign br_eq  = in_rs_left_oprand == in_rs_right_oprand;
    assign br_lt  = $signed(in_rs_left_oprand) < $signed(in_rs_right_oprand);
    assign br_ltu = in_rs_left_oprand < in_rs_right_oprand;

    always_comb begin
        br_taken = 1'b0;
        case (in_rs_type)
            OP_BEQ:  br_taken = br_eq;
            OP_BNE:  br_taken = !br_eq;
            OP_BLT:  br_taken = br_lt;
            OP_BGE:  br_taken = !br_lt;
            OP_BLTU: br_taken = br_ltu;
            OP_BGEU: br_taken = !br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH-1:0] pc_plus_imm;
    logic [ADDRESS_WIDTH-1:0] jalr_sum;

    assign pc_plus4    = in_rs_pc + 32'd4;
    assign pc_plus_imm = in_rs_pc + in_rs_imm;
    assign jalr_sum    = in_rs_left_oprand + in_rs_imm;

    logic [DATA_WIDTH-1:0]    res_d;
    logic                     jump_d;
    logic [ADDRESS_WIDTH-1:0] target_d;

    always_comb begin
        res_d    = '0;
        jump_d   = 1'b0;
        target_d = pc_plus4;
        case (op_class)
            ClsAlu: res_d = alu_out;
            ClsBranch: begin
                jump_d   = br_taken;
                target_d = pc_plus_imm;
            end
            ClsOther: begin
                case (in_rs_type)
                    OP_LUI:   res_d = in_rs_imm;
                    OP_AUIPC: res_d = pc_plus_imm;
                    OP_JAL: begin
                        res_d    = pc_plus4;
                        jump_d   = 1'b1;
                        target_d = pc_plus_imm;
                    end
                    OP_JALR: begin
                        res_d    = pc_plus4;
                        jump_d   = 1'b1;
                        target_d = jalr_sum & ~32'd1;
                    end
                    default: res_d = '0;
                endcase
            end
            default: res_d = '0;
        endcase
    end

    logic accept;
    assign accept = in_rs_enable && !in_clear && (in_rs_dest != ZERO_ROB);

    logic                     enable_q;
    logic [ROB_WIDTH-1:0]     reorder_q;
    logic [DATA_WIDTH-1:0]    result_q;
    logic                     jump_q;
    logic [ADDRESS_WIDTH-1:0] target_q;

    // Payload registers only load on accept so a dropped issue leaves the last broadcast visible.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            enable_q  <= 1'b0;
            reorder_q <= '0;
            result_q  <= '0;
            jump_q    <= 1'b0;
            target_q  <= '0;
        end else if (in_rdy) begin
            enable_q <= accept;
            if (accept) begin
                reorder_q <= in_rs_dest;
                result_q  <= res_d;
                jump_q    <= jump_d;
                target_q  <= target_d;
            end
        end
    end

    assign out_broadcast_enable  = enable_q;
    assign out_broadcast_reorder = reorder_q;
    assign out_broadcast_result  = result_q;
    assign out_broadcast_jump    = jump_q;
    assign out_broadcast_target  = target_q;

endmodule
